ahb_apb_bridge: RTL and testbench
=================================

Name: ahb_apb_bridge

Overview:
- AHB slave that converts single AHB transfers into APB3 transfers toward up to NUM_APB_SLAVES peripherals.
- Sits beside the SRAM/default/split slaves in the AHB subsystem, selected by the decoder via HSEL_APB.
- Its hrdata/hready/hresp/hsplit outputs feed the AHB response mux as a new arm.
- APB side runs on the same clock; one APB transfer is in flight at a time.

Parameters:
- ADDR_WIDTH, 32, AHB/APB address width.
- DATA_WIDTH, 32, data width.
- NO_OF_MASTERS, 4, HSPLIT width.
- NUM_APB_SLAVES, 4, number of PSEL lines; each slave owns a 4 KB window selected by HADDR[13:12] upward.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- HSEL_APB  in  1  decoder select.
- HADDR  in  ADDR_WIDTH  address.
- HTRANS  in  2  transfer type.
- HWRITE  in  1  write.
- HWDATA  in  DATA_WIDTH  write data (data phase).
- HREADY  in  1  bus-level HREADY from the response mux.
- hrdata_apb  out  DATA_WIDTH  read data to the mux.
- hready_apb  out  1  ready to the mux.
- hresp_apb  out  2  response to the mux.
- hsplit_apb  out  NO_OF_MASTERS  always 0.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  NUM_APB_SLAVES  one-hot select.
- PENABLE  out  1  access phase.
- PWRITE  out  1  direction.
- PWDATA  out  DATA_WIDTH  write data.
- PRDATA  in  DATA_WIDTH  read data from the selected slave (pre-muxed externally).
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset values: hready_apb=1; hresp_apb=OKAY; hrdata_apb=0; PSEL=0; PENABLE=0; PADDR=0; PWRITE=0; PWDATA=0; state=IDLE. Reset asserted mid-transfer drops PSEL/PENABLE immediately; no completion is signalled.
- Accept condition: HSEL_APB & HTRANS[1] & HREADY. On accept, latch HADDR, HWRITE and slave index = HADDR[13:12].
- Out-of-range index (>= NUM_APB_SLAVES): go to ERR1 with no APB activity.
- HTRANS IDLE/BUSY while selected: OKAY, zero wait states, no APB activity.
- FSM states: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
- IDLE: hready_apb=1. On accept, a write goes to WWAIT, a read goes to SETUP.
- WWAIT (writes only): hready_apb=0. Latch HWDATA into the PWDATA register, then go to SETUP.
- SETUP: PSEL[idx]=1, PENABLE=0, hready_apb=0. Next state is ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1.
  - PREADY=0: stay in ACCESS, hready_apb=0.
  - PREADY=1 and PSLVERR=0: hready_apb=1, hresp=OKAY, hrdata_apb=PRDATA (reads; 0 for writes). Next state is IDLE, or directly WWAIT/SETUP if a new accept is present in the same cycle (back-to-back pipelining).
  - PREADY=1 and PSLVERR=1: hready_apb=0, hresp=ERROR, PSEL/PENABLE drop next cycle, go to ERR2.
- ERR1: hready_apb=0, hresp=ERROR, go to ERR2.
- ERR2: hready_apb=1, hresp=ERROR. Accepts a new transfer exactly like the IDLE/ACCESS completion cycle.
- Minimum latency: read completes with 1 AHB wait state; write with 2 wait states; each PREADY-low cycle adds one wait state.
- PADDR, PWRITE and PWDATA stay stable from SETUP through the end of ACCESS. PENABLE is never high outside ACCESS, and PSEL is at most one-hot.
- hrdata_apb is 0 outside the ACCESS completion cycle.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ).
  - HRESP encodings (OKAY/ERROR/RETRY/SPLIT).
  - DATA_WIDTH, ADDR_WIDTH, NO_OF_MASTERS.
  - The bridge state enum typedef.
- One combinational sub-module, apb_psel_decoder: slave index plus valid flag to one-hot PSEL and an out-of-range flag.

Test Plan:
- Read 0x0000_1004, PREADY=1, PRDATA=0xCAFE_F00D -> PSEL=0b0010 for 1 SETUP + 1 ACCESS cycle; hready_apb low 1 cycle; hrdata_apb=0xCAFE_F00D with OKAY.
- Write 0x0000_3010, HWDATA=0x1234_5678, PREADY low 2 cycles -> PWDATA=0x1234_5678 stable SETUP through ACCESS; PSEL=0b1000; 4 wait states total; OKAY.
- Read with PREADY=1, PSLVERR=1 -> two-cycle ERROR (hready 0 then 1, hresp=01 both cycles); PSEL low after the ACCESS cycle.
- Out-of-range address with NUM_APB_SLAVES=2 (HADDR=0x0000_2000) -> no PSEL activity; two-cycle ERROR.
- Back-to-back NONSEQ write then read, second address presented during the write's completion cycle -> read SETUP starts the next cycle, no IDLE bubble; then HTRANS=IDLE -> OKAY, zero wait.
- HRESET asserted during ACCESS -> PSEL=0, PENABLE=0, hready_apb=1 asynchronously; the first transfer after release behaves as a normal read.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/response encodings, default bus widths and
// the AHB-to-APB bridge state type.
package ahb_pkg;

   localparam int AHB_ADDR_WIDTH    = 32;
   localparam int AHB_DATA_WIDTH    = 32;
   localparam int AHB_NO_OF_MASTERS = 4;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [1:0] HRESP_RETRY = 2'b10;
   localparam logic [1:0] HRESP_SPLIT = 2'b11;

   // Each APB slave owns a 4 KB window; the index sits just above it.
   localparam int APB_IDX_LSB = 12;
   localparam int APB_IDX_W   = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WWAIT,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } bridge_state_t;

endpackage

// File: rtl/apb_psel_decoder.sv
// Slave index to one-hot PSEL plus out-of-range flag; purely combinational.
// Both outputs are forced low when vld is low.
module apb_psel_decoder
   import ahb_pkg::*;
#(
   parameter int NUM_SLAVES = 4
) (
   input  logic [APB_IDX_W-1:0]  idx,
   input  logic                  vld,
   output logic [NUM_SLAVES-1:0] psel,
   output logic                  oor
);

   always_comb begin
      psel = '0;
      oor  = vld && (int'(idx) >= NUM_SLAVES);
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (vld && (int'(idx) == i)) begin
            psel[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB slave converting single transfers into APB3 transfers, one in flight.
// Read: 1 wait state, write: 2, plus one per PREADY-low cycle; errors are two-cycle.
module ahb_apb_bridge
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH     = AHB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = AHB_DATA_WIDTH,
   parameter int NO_OF_MASTERS  = AHB_NO_OF_MASTERS,
   parameter int NUM_APB_SLAVES = 4
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic                      HSEL_APB,
   input  logic [ADDR_WIDTH-1:0]     HADDR,
   input  logic [1:0]                HTRANS,
   input  logic                      HWRITE,
   input  logic [DATA_WIDTH-1:0]     HWDATA,
   input  logic                      HREADY,
   output logic [DATA_WIDTH-1:0]     hrdata_apb,
   output logic                      hready_apb,
   output logic [1:0]                hresp_apb,
   output logic [NO_OF_MASTERS-1:0]  hsplit_apb,
   output logic [ADDR_WIDTH-1:0]     PADDR,
   output logic [NUM_APB_SLAVES-1:0] PSEL,
   output logic                      PENABLE,
   output logic                      PWRITE,
   output logic [DATA_WIDTH-1:0]     PWDATA,
   input  logic [DATA_WIDTH-1:0]     PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   bridge_state_t             state_q, state_d, start_state;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic                      write_q;
   logic [NUM_APB_SLAVES-1:0] psel_q, psel_req;
   logic [DATA_WIDTH-1:0]     pwdata_q;
   logic                      accept, oor_req, take, apb_active, pwdata_load;

   assign accept = HSEL_APB && HREADY && (HTRANS != HTRANS_IDLE) && (HTRANS != HTRANS_BUSY);

   apb_psel_decoder #(
      .NUM_SLAVES (NUM_APB_SLAVES)
   ) u_psel_dec (
      .idx  (HADDR[APB_IDX_LSB +: APB_IDX_W]),
      .vld  (accept),
      .psel (psel_req),
      .oor  (oor_req)
   );

   assign start_state = oor_req ? ST_ERR1 : (HWRITE ? ST_WWAIT : ST_SETUP);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         write_q  <= 1'b0;
         psel_q   <= '0;
         pwdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (take && accept) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            psel_q  <= psel_req;
         end
         if (pwdata_load) begin
            pwdata_q <= HWDATA;
         end
      end
   end

   // take marks the cycles in which a new address phase may be accepted.
   always_comb begin
      state_d     = state_q;
      hready_apb  = 1'b1;
      hresp_apb   = HRESP_OKAY;
      hrdata_apb  = '0;
      apb_active  = 1'b0;
      PENABLE     = 1'b0;
      take        = 1'b0;
      pwdata_load = 1'b0;
      case (state_q)
         ST_IDLE, ST_ERR2: begin
            if (state_q == ST_ERR2) begin
               hresp_apb = HRESP_ERROR;
            end
            take    = 1'b1;
            state_d = accept ? start_state : ST_IDLE;
         end
         ST_WWAIT: begin
            hready_apb  = 1'b0;
            pwdata_load = 1'b1;
            state_d     = ST_SETUP;
         end
         ST_SETUP: begin
            hready_apb = 1'b0;
            apb_active = 1'b1;
            state_d    = ST_ACCESS;
         end
         ST_ACCESS: begin
            apb_active = 1'b1;
            PENABLE    = 1'b1;
            if (!PREADY) begin
               hready_apb = 1'b0;
            end else if (PSLVERR) begin
               hready_apb = 1'b0;
               hresp_apb  = HRESP_ERROR;
               state_d    = ST_ERR2;
            end else begin
               hrdata_apb = write_q ? '0 : PRDATA;
               take       = 1'b1;
               state_d    = accept ? start_state : ST_IDLE;
            end
         end
         ST_ERR1: begin
            hready_apb = 1'b0;
            hresp_apb  = HRESP_ERROR;
            state_d    = ST_ERR2;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign PSEL       = apb_active ? psel_q : '0;
   assign PADDR      = addr_q;
   assign PWRITE     = write_q;
   assign PWDATA     = pwdata_q;
   assign hsplit_apb = '0;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: a 4-slave instance for normal traffic and
// a 2-slave instance for the out-of-range window.
module tb_ahb_apb_bridge;
   import ahb_pkg::*;

   logic        clk, rst;
   logic        sel_a, sel_b;
   logic [31:0] haddr, hwdata, prdata;
   logic [1:0]  htrans;
   logic        hwrite, pready, pslverr;

   logic [31:0] hrdata_a, paddr_a, pwdata_a;
   logic        hready_a, penable_a, pwrite_a;
   logic [1:0]  hresp_a;
   logic [3:0]  hsplit_a, psel_a;

   logic [31:0] hrdata_b, paddr_b, pwdata_b;
   logic        hready_b, penable_b, pwrite_b;
   logic [1:0]  hresp_b;
   logic [3:0]  hsplit_b;
   logic [1:0]  psel_b;

   int n_cmp = 0;
   int n_bad = 0;
   int waits;

   ahb_apb_bridge #(.NUM_APB_SLAVES(4)) u_dut (
      .HCLK(clk), .HRESET(rst), .HSEL_APB(sel_a), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready_a),
      .hrdata_apb(hrdata_a), .hready_apb(hready_a), .hresp_apb(hresp_a), .hsplit_apb(hsplit_a),
      .PADDR(paddr_a), .PSEL(psel_a), .PENABLE(penable_a), .PWRITE(pwrite_a), .PWDATA(pwdata_a),
      .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
   );

   ahb_apb_bridge #(.NUM_APB_SLAVES(2)) u_dut2 (
      .HCLK(clk), .HRESET(rst), .HSEL_APB(sel_b), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready_b),
      .hrdata_apb(hrdata_b), .hready_apb(hready_b), .hresp_apb(hresp_b), .hsplit_apb(hsplit_b),
      .PADDR(paddr_b), .PSEL(psel_b), .PENABLE(penable_b), .PWRITE(pwrite_b), .PWDATA(pwdata_b),
      .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; sel_a = 1'b0; sel_b = 1'b0; haddr = '0; htrans = HTRANS_IDLE;
      hwrite = 1'b0; hwdata = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;

      // Reset state, sampled before any clock edge
      #3;
      chk("rst_hready", 32'(hready_a), 32'h1);
      chk("rst_hresp", 32'(hresp_a), 32'(HRESP_OKAY));
      chk("rst_hrdata", hrdata_a, 32'h0);
      chk("rst_psel", 32'(psel_a), 32'h0);
      chk("rst_penable", 32'(penable_a), 32'h0);
      chk("rst_paddr", paddr_a, 32'h0);
      chk("rst_pwrite", 32'(pwrite_a), 32'h0);
      chk("rst_pwdata", pwdata_a, 32'h0);
      chk("rst_hsplit", 32'(hsplit_a), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Read 0x1004 with zero-wait slave
      sel_a = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h0000_1004; hwrite = 1'b0;
      pready = 1'b1; prdata = 32'hCAFE_F00D;
      @(negedge clk);
      chk("rd_addr_hready", 32'(hready_a), 32'h1);
      chk("rd_addr_psel", 32'(psel_a), 32'h0);
      step(); htrans = HTRANS_IDLE;
      @(negedge clk);
      chk("rd_setup_psel", 32'(psel_a), 32'h2);
      chk("rd_setup_penable", 32'(penable_a), 32'h0);
      chk("rd_setup_hready", 32'(hready_a), 32'h0);
      chk("rd_setup_paddr", paddr_a, 32'h0000_1004);
      chk("rd_setup_hrdata", hrdata_a, 32'h0);
      step();
      @(negedge clk);
      chk("rd_acc_psel", 32'(psel_a), 32'h2);
      chk("rd_acc_penable", 32'(penable_a), 32'h1);
      chk("rd_acc_hready", 32'(hready_a), 32'h1);
      chk("rd_acc_hrdata", hrdata_a, 32'hCAFE_F00D);
      chk("rd_acc_hresp", 32'(hresp_a), 32'(HRESP_OKAY));
      step();
      @(negedge clk);
      chk("rd_done_psel", 32'(psel_a), 32'h0);
      chk("rd_done_hrdata", hrdata_a, 32'h0);

      // Write 0x3010 with PREADY low for two ACCESS cycles
      step();
      htrans = HTRANS_NONSEQ; haddr = 32'h0000_3010; hwrite = 1'b1; pready = 1'b0;
      prdata = 32'hDEAD_BEEF; waits = 0;
      @(negedge clk);
      chk("wr_addr_hready", 32'(hready_a), 32'h1);
      step(); htrans = HTRANS_IDLE; hwdata = 32'h1234_5678;
      @(negedge clk);
      if (!hready_a) waits++;
      chk("wr_wwait_psel", 32'(psel_a), 32'h0);
      step(); hwdata = 32'h0;
      @(negedge clk);
      if (!hready_a) waits++;
      chk("wr_setup_psel", 32'(psel_a), 32'h8);
      chk("wr_setup_penable", 32'(penable_a), 32'h0);
      chk("wr_setup_pwdata", pwdata_a, 32'h1234_5678);
      chk("wr_setup_pwrite", 32'(pwrite_a), 32'h1);
      chk("wr_setup_paddr", paddr_a, 32'h0000_3010);
      step();
      @(negedge clk);
      if (!hready_a) waits++;
      chk("wr_acc1_penable", 32'(penable_a), 32'h1);
      chk("wr_acc1_pwdata", pwdata_a, 32'h1234_5678);
      step();
      @(negedge clk);
      if (!hready_a) waits++;
      chk("wr_acc2_paddr", paddr_a, 32'h0000_3010);
      step(); pready = 1'b1;
      @(negedge clk);
      if (!hready_a) waits++;
      chk("wr_done_hready", 32'(hready_a), 32'h1);
      chk("wr_done_hresp", 32'(hresp_a), 32'(HRESP_OKAY));
      chk("wr_done_hrdata", hrdata_a, 32'h0);
      chk("wr_done_psel", 32'(psel_a), 32'h8);
      chk("wr_done_pwdata", pwdata_a, 32'h1234_5678);
      chk("wr_wait_states", 32'(waits), 32'd4);

      // Read with slave error
      step();
      htrans = HTRANS_NONSEQ; haddr = 32'h0000_0008; hwrite = 1'b0;
      pslverr = 1'b1; prdata = 32'h1111_2222;
      step(); htrans = HTRANS_IDLE;
      @(negedge clk);
      chk("err_setup_psel", 32'(psel_a), 32'h1);
      step();
      @(negedge clk);
      chk("err_acc_penable", 32'(penable_a), 32'h1);
      chk("err_acc_hready", 32'(hready_a), 32'h0);
      chk("err_acc_hresp", 32'(hresp_a), 32'(HRESP_ERROR));
      chk("err_acc_hrdata", hrdata_a, 32'h0);
      step();
      @(negedge clk);
      chk("err2_hready", 32'(hready_a), 32'h1);
      chk("err2_hresp", 32'(hresp_a), 32'(HRESP_ERROR));
      chk("err2_psel", 32'(psel_a), 32'h0);
      chk("err2_penable", 32'(penable_a), 32'h0);
      step(); pslverr = 1'b0;
      @(negedge clk);
      chk("err_after_hresp", 32'(hresp_a), 32'(HRESP_OKAY));

      // Out-of-range index on the 2-slave instance
      step();
      sel_a = 1'b0; sel_b = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h0000_2000; hwrite = 1'b0;
      @(negedge clk);
      chk("oor_addr_hready", 32'(hready_b), 32'h1);
      step(); htrans = HTRANS_IDLE;
      @(negedge clk);
      chk("oor_err1_hready", 32'(hready_b), 32'h0);
      chk("oor_err1_hresp", 32'(hresp_b), 32'(HRESP_ERROR));
      chk("oor_err1_psel", 32'(psel_b), 32'h0);
      step();
      @(negedge clk);
      chk("oor_err2_hready", 32'(hready_b), 32'h1);
      chk("oor_err2_hresp", 32'(hresp_b), 32'(HRESP_ERROR));
      chk("oor_err2_psel", 32'(psel_b), 32'h0);
      chk("oor_err2_penable", 32'(penable_b), 32'h0);
      step(); sel_b = 1'b0; sel_a = 1'b1;

      // Back-to-back write then read, then IDLE and BUSY
      htrans = HTRANS_NONSEQ; haddr = 32'h0000_2000; hwrite = 1'b1;
      step(); htrans = HTRANS_IDLE; hwdata = 32'hAABB_CCDD;
      @(negedge clk);
      chk("b2b_wwait_hready", 32'(hready_a), 32'h0);
      step();
      @(negedge clk);
      chk("b2b_wsetup_psel", 32'(psel_a), 32'h4);
      step();
      htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 32'h0000_1008; prdata = 32'h55AA_55AA;
      @(negedge clk);
      chk("b2b_wdone_hready", 32'(hready_a), 32'h1);
      chk("b2b_wdone_penable", 32'(penable_a), 32'h1);
      chk("b2b_wdone_psel", 32'(psel_a), 32'h4);
      chk("b2b_wdone_pwdata", pwdata_a, 32'hAABB_CCDD);
      chk("b2b_wdone_hrdata", hrdata_a, 32'h0);
      step(); htrans = HTRANS_IDLE;
      @(negedge clk);
      chk("b2b_rsetup_psel", 32'(psel_a), 32'h2);
      chk("b2b_rsetup_penable", 32'(penable_a), 32'h0);
      chk("b2b_rsetup_hready", 32'(hready_a), 32'h0);
      chk("b2b_rsetup_pwrite", 32'(pwrite_a), 32'h0);
      chk("b2b_rsetup_paddr", paddr_a, 32'h0000_1008);
      step();
      @(negedge clk);
      chk("b2b_rdone_hrdata", hrdata_a, 32'h55AA_55AA);
      chk("b2b_rdone_hready", 32'(hready_a), 32'h1);
      step();
      @(negedge clk);
      chk("idle_hready", 32'(hready_a), 32'h1);
      chk("idle_hresp", 32'(hresp_a), 32'(HRESP_OKAY));
      chk("idle_psel", 32'(psel_a), 32'h0);
      step(); htrans = HTRANS_BUSY;
      @(negedge clk);
      chk("busy_hready", 32'(hready_a), 32'h1);
      step(); htrans = HTRANS_IDLE;
      @(negedge clk);
      chk("busy_after_psel", 32'(psel_a), 32'h0);
      chk("busy_after_hready", 32'(hready_a), 32'h1);

      // Reset during ACCESS, then a normal read
      step();
      htrans = HTRANS_NONSEQ; haddr = 32'h0000_3000; hwrite = 1'b0; pready = 1'b0;
      prdata = 32'h7777_8888;
      step(); htrans = HTRANS_IDLE;
      @(negedge clk);
      chk("rstx_setup_psel", 32'(psel_a), 32'h8);
      step();
      @(negedge clk);
      chk("rstx_acc_penable", 32'(penable_a), 32'h1);
      chk("rstx_acc_hready", 32'(hready_a), 32'h0);
      chk("rstx_acc_hrdata", hrdata_a, 32'h0);
      #2 rst = 1'b1;
      #1;
      chk("rstx_async_psel", 32'(psel_a), 32'h0);
      chk("rstx_async_penable", 32'(penable_a), 32'h0);
      chk("rstx_async_hready", 32'(hready_a), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      step();
      htrans = HTRANS_NONSEQ; haddr = 32'h0000_1000; pready = 1'b1; prdata = 32'h0BAD_BEEF;
      @(negedge clk);
      chk("post_addr_hready", 32'(hready_a), 32'h1);
      step(); htrans = HTRANS_IDLE;
      @(negedge clk);
      chk("post_setup_psel", 32'(psel_a), 32'h2);
      chk("post_setup_hready", 32'(hready_a), 32'h0);
      step();
      @(negedge clk);
      chk("post_acc_hrdata", hrdata_a, 32'h0BAD_BEEF);
      chk("post_acc_hready", 32'(hready_a), 32'h1);
      chk("post_acc_hresp", 32'(hresp_a), 32'(HRESP_OKAY));
      step();
      @(negedge clk);
      chk("post_done_psel", 32'(psel_a), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
